serial_subtractor: RTL and testbench

Bit-serial multi-bit subtractor that computes `a - b` LSB-first, one bit per clock, using a single full-subtractor cell and a registered borrow. It sits directly downstream of the operand source and wraps the subtractor cell into a handshaked, sequential datapath. It trades area for latency: one cell plus shift registers replace a WIDTH-bit ripple subtractor.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Purpose: FSM state encoding, default operand width and the bit-counter
//          width helper used by serial_subtractor.
// Ports:   none (package).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter only has to reach width-1, so $clog2(width) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full-subtractor cell
//
// Purpose: computes a - b - bin for single bits.
// Ports:   a    in  1  minuend bit
//          b    in  1  subtrahend bit
//          bin  in  1  borrow in
//          d    out 1  difference bit
//          bout out 1  borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - handshaked LSB-first bit-serial subtractor
//
// Purpose: computes (a - b) mod 2^WIDTH one bit per clock through a single
//          full_subtractor cell with a registered borrow. One operation in
//          flight; IDLE accepts, SHIFT runs WIDTH cycles, DONE holds result.
// Ports:   clk        in  1      rising-edge clock
//          rst_n      in  1      asynchronous active-low reset
//          in_valid   in  1      operands valid
//          in_ready   out 1      block can accept operands (IDLE only)
//          a          in  WIDTH  minuend
//          b          in  WIDTH  subtrahend
//          out_valid  out 1      result valid (DONE)
//          out_ready  in  1      consumer accepts result
//          difference out WIDTH  (a - b) mod 2^WIDTH
//          borrow     out 1      1 iff a < b (unsigned)
//          overflow   out 1      signed overflow, only with SERIAL_SUB_OVF_EN
// Config:  SERIAL_SUB_OVF_EN adds the overflow port and operand-MSB capture.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result fills from the MSB end so that after WIDTH shifts bit 0
        // lands in diff_q[0].
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        bin_d  = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      bin_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated with rst_n so the block never advertises readiness while held in reset.
  assign in_ready   = rst_n & (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign difference = diff_q;
  // After the last bit the borrow register holds the final borrow-out.
  assign borrow     = bin_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted away during SHIFT, so keep copies for the flag.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign overflow = (a_msb_q ^ b_msb_q) & (diff_q[WIDTH-1] ^ a_msb_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] difference;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_i),
    .b          (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow     (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc_edge;
  } txn_t;

  txn_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   results_done = 0;
  bit   busy = 0;
  bit   prev_ov = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic bit model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    sd = $signed(x) - $signed(y);
    return (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs on every falling edge: inputs and outputs are settled here.
  task automatic monitor_step();
    logic [W-1:0] exp_d;
    logic         exp_b;
    if (!rst_n) begin
      chk(in_ready == 1'b0 && out_valid == 1'b0, "reset_hs", {in_ready, out_valid}, 0);
      q.delete();
      busy    = 0;
      prev_ov = 0;
    end else begin
      chk(in_ready == !busy, "in_ready", in_ready, !busy);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "spurious_valid", out_valid, 0);
        end else begin
          exp_d = q[0].a - q[0].b;
          exp_b = (q[0].a < q[0].b);
          chk(difference == exp_d, "model_diff", difference, exp_d);
          chk(borrow == exp_b, "model_borrow", borrow, exp_b);
`ifdef SERIAL_SUB_OVF_EN
          chk(overflow == model_ovf(q[0].a, q[0].b), "model_ovf", overflow, model_ovf(q[0].a, q[0].b));
`endif
          if (!prev_ov)
            chk(edge_cnt == q[0].acc_edge + W, "latency", edge_cnt, q[0].acc_edge + W);
          if (out_ready) begin
            void'(q.pop_front());
            busy = 0;
            results_done++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{a: a_i, b: b_i, acc_edge: edge_cnt + 1});
        busy = 1;
      end
      prev_ov = out_valid;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] dv,
                        input logic bwv, input logic ovv, input int hold);
    int n;
    @(posedge clk); #1;
    a_i = av; b_i = bv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk(in_ready == 1'b1, "accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk(n == W, "lit_latency", n, W);
    chk(difference == dv, "lit_diff", difference, dv);
    chk(borrow == bwv, "lit_borrow", borrow, bwv);
`ifdef SERIAL_SUB_OVF_EN
    chk(overflow == ovv, "lit_ovf", overflow, ovv);
`else
    chk(model_ovf(av, bv) == ovv, "lit_model_ovf", model_ovf(av, bv), ovv);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk(out_valid == 1'b1 && difference == dv && borrow == bwv, "hold_stable", difference, dv);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(out_valid == 1'b0 && in_ready == 1'b1, "back_to_idle", {out_valid, in_ready}, 1);
  endtask

  initial begin
    int n;
    int target;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b0 && out_valid == 1'b0, "rst_hs", {in_ready, out_valid}, 0);
    chk(difference == '0 && borrow == 1'b0, "rst_data", difference, 0);
    rst_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "ready_after_rst", in_ready, 1);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h01, 8'h80, 8'h81, 1'b1, 1'b1, 0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 5);

    // Reset in the middle of SHIFT: the partial result must vanish.
    @(posedge clk); #1;
    a_i = 8'h55; b_i = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0 && in_ready == 1'b0, "midrst_hs", {out_valid, in_ready}, 0);
    chk(difference == '0 && borrow == 1'b0, "midrst_data", difference, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "midrst_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk(out_valid == 1'b0, "midrst_no_valid", out_valid, 0);
    end
    run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 0);

    // in_valid held high with fresh operands every cycle; only IDLE ones count.
    target = results_done + 200;
    in_valid = 1'b1;
    n = 0;
    while (results_done < target && n < 8000) begin
      a_i = W'($urandom);
      b_i = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    chk(results_done >= target, "stream_done", results_done, target);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk(q.size() == 0 && !busy, "drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
